// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data.
// Data wins by default; fetch is forced after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [16:0] if_rdata,
  output logic        if_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [16:0] m_wdata,
  input  logic [16:0] m_rdata,
  input  logic        m_ack,
  output logic        stall,
  output logic        err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST =
    (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic          own_q, own_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [15:0]   addr_q, addr_d;
  logic [16:0]   wdata_q, wdata_d;
  logic [16:0]   rdata_q, rdata_d;
  logic [3:0]    starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic d_req, force_f, gnt_f, gnt_d, tmo_hit;

  assign d_req   = d_read | d_write;
  assign force_f = if_req & (starve_q == SLIM);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TLAST);

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    gnt_f    = 1'b0;
    gnt_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = d_req & ~force_f;
        gnt_f = if_req & ~gnt_d;
        if (gnt_d | gnt_f) begin
          state_d = BUSY;
          own_d   = gnt_d;
          we_d    = gnt_d & d_write;
          err_d   = gnt_d & d_read & d_write;
          addr_d  = gnt_d ? d_addr : if_addr;
          wdata_d = {1'b0, d_wdata};
          tmo_d   = '0;
        end
      end
      BUSY: begin
        if (m_ack) begin
          rdata_d = m_rdata;
          state_d = DONE;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counts data wins over a waiting fetch; saturates at the limit.
    if (!if_req || gnt_f) begin
      starve_d = '0;
    end else if (gnt_d && starve_q != SLIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  assign m_req    = (state_q == BUSY);
  assign m_we     = we_q & m_req;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_ready = (state_q == DONE) & ~own_q;
  assign d_ready  = (state_q == DONE) & own_q;
  assign err      = (state_q == DONE) & err_q;
  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q[15:0];
  assign stall    = (if_req | d_req) & ~(if_ready | d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random traffic against a transaction-level arbiter model.
// Grants, bus fields, responses and stall are scored through queues.
module tb_mem_arbiter;
  localparam int SL = 2;
  localparam int TO = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [16:0] if_rdata;
  logic        if_ready;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [16:0] m_wdata;
  logic [16:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        stall;
  logic        err;

  mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall(stall), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          data;
    bit          we;
    logic [15:0] addr;
    logic [16:0] wdata;
    bit          ill;
    int          cyc;
  } gnt_t;

  typedef struct {
    bit          data;
    logic [16:0] rdata;
    bit          err;
    int          cyc;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  logic [16:0] mem [logic [15:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Requester and arbitration model state
  bit f_pend, f_gnt, f_drop;
  bit d_pend, d_gnt, d_drop;
  bit d_rd, d_wr;
  bit free, rdy_prev;
  int starve;

  task automatic clear_model();
    f_pend = 0; f_gnt = 0; f_drop = 0;
    d_pend = 0; d_gnt = 0; d_drop = 0;
    d_rd = 0; d_wr = 0;
    free = 0; rdy_prev = 0; starve = 0;
    if_req = 0; d_read = 0; d_write = 0;
  endtask

  task automatic step(int pf, int pd);
    gnt_t g;
    bit dwin;
    int k;
    @(negedge clock);
    if (rdy_prev) free = 1;
    rdy_prev = if_ready | d_ready;
    chk("stall", stall,
        (if_req | d_read | d_write) & ~(if_ready | d_ready));
    if (if_ready) begin f_pend = 0; f_gnt = 0; end
    if (d_ready) begin d_pend = 0; d_gnt = 0; end
    if (!f_pend && $urandom_range(99) < pf) begin
      f_pend = 1;
      if_addr = 16'($urandom);
    end
    if (!d_pend && $urandom_range(99) < pd) begin
      d_pend = 1;
      k = $urandom_range(7);
      d_rd = (k < 4);
      d_wr = (k >= 4) || (k == 0);
      d_addr = {12'h0, 4'($urandom)};
      d_wdata = 16'($urandom);
    end
    if_req  = f_pend && !(f_gnt && f_drop);
    d_read  = d_pend && d_rd && !(d_gnt && d_drop);
    d_write = d_pend && d_wr && !(d_gnt && d_drop);
    if (free && (if_req || d_read || d_write)) begin
      dwin = (d_read || d_write) && !(if_req && starve == SL);
      g.data  = dwin;
      g.we    = dwin && d_write;
      g.addr  = dwin ? d_addr : if_addr;
      g.wdata = {1'b0, d_wdata};
      g.ill   = dwin && d_read && d_write;
      g.cyc   = cyc;
      gq.push_back(g);
      free = 0;
      if (dwin) begin
        d_gnt = 1;
        d_drop = ($urandom_range(3) == 0);
        starve = if_req ? ((starve < SL) ? starve + 1 : SL) : 0;
      end else begin
        f_gnt = 1;
        f_drop = ($urandom_range(3) == 0);
        starve = 0;
      end
    end else if (!if_req) begin
      starve = 0;
    end
  endtask

  // Memory: checks each access against the granted request and answers it
  initial begin : memory
    gnt_t g;
    rsp_t r;
    bit act, to;
    int bc, wn;
    act = 0; to = 0; bc = 0; wn = 0;
    forever begin
      @(negedge clock);
      m_ack = ($urandom_range(3) == 0) && !m_req;
      m_rdata = 17'($urandom);
      if (reset !== 1'b1) begin
        act = 0;
        continue;
      end
      if (m_req && !act) begin
        if (gq.size() == 0) begin
          flag("unexpected grant");
        end else begin
          g = gq.pop_front();
          chk("grant latency", cyc, g.cyc + 1);
          act = 1; bc = 0;
          to = ($urandom_range(7) == 0);
          wn = $urandom_range(3);
        end
      end else if (!m_req && gq.size() > 0 && cyc > gq[0].cyc) begin
        flag("missing grant");
        void'(gq.pop_front());
      end
      if (m_req && act) begin
        chk("m_addr", m_addr, g.addr);
        chk("m_we", m_we, g.we);
        if (g.we) chk("m_wdata", m_wdata, g.wdata);
        if (!to && bc == wn) begin
          if (g.we) begin
            mem[g.addr] = g.wdata;
          end else if (mem.exists(g.addr)) begin
            m_rdata = mem[g.addr];
          end else begin
            m_rdata = {^g.addr, g.addr ^ 16'h5A3C};
          end
          m_ack = 1;
          r.data = g.data; r.rdata = m_rdata;
          r.err = g.ill; r.cyc = cyc;
          rq.push_back(r);
          act = 0;
        end else if (to && bc == TO - 1) begin
          r.data = g.data; r.rdata = '0;
          r.err = 1; r.cyc = cyc;
          rq.push_back(r);
          act = 0;
        end
        bc++;
      end
    end
  end

  // Response monitor
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        chk("ready in reset", {if_ready, d_ready, err}, 0);
        continue;
      end
      if (if_ready || d_ready) begin
        if (rq.size() == 0) begin
          flag("unexpected ready");
        end else begin
          r = rq.pop_front();
          chk("ready owner", {if_ready, d_ready},
              r.data ? 2'b01 : 2'b10);
          chk("ready latency", cyc, r.cyc + 1);
          if (r.data) chk("d_rdata", d_rdata, r.rdata[15:0]);
          else        chk("if_rdata", if_rdata, r.rdata);
          chk("err", err, r.err);
        end
      end else begin
        if (err) flag("err without ready");
        if (rq.size() > 0 && cyc > rq[0].cyc + 1) begin
          flag("missing ready");
          void'(rq.pop_front());
        end
      end
    end
  end

  task automatic reset_mid();
    int n;
    n = 0;
    while (!m_req && n < 50) begin
      step(100, 50);
      n++;
    end
    chk("busy before reset", m_req, 1);
    #2 reset = 1'b0;
    #1 chk("m_req async drop", m_req, 0);
    gq.delete();
    rq.delete();
    clear_model();
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    free = 1;
  endtask

  initial begin
    clear_model();
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset m_*", {m_req, m_we, m_addr, m_wdata}, 0);
    chk("reset ready/err", {if_ready, d_ready, err}, 0);
    chk("reset if_rdata", if_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    reset = 1'b1;
    free = 1;
    repeat (300) step(50, 50);
    repeat (80) step(100, 100);
    reset_mid();
    repeat (6) step(100, 0);
    repeat (300) step(30, 70);
    repeat (40) step(0, 0);
    chk("grant queue drained", gq.size(), 0);
    chk("resp queue drained", rq.size(), 0);
    chk("requests drained", {f_pend, d_pend}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory port. It sits between the CPU's imem/dmem ports and the physical memory. It serializes accesses and returns a one-cycle ready pulse per completed access. It also provides starvation protection for fetch, a bus timeout, and a stall output the pipeline uses to freeze PC and pipeline registers.

## Interface
Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending before fetch is forced (1..15).
- TIMEOUT, 64, number of BUSY cycles without m_ack before abort; 0 disables the timeout.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- if_req  in  1  fetch request level, held until if_ready.
- if_addr  in  16  fetch address.
- if_rdata  out  17  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_read  in  1  data read request level.
- d_write  in  1  data write request level.
- d_addr  in  16  data address.
- d_wdata  in  16  write data.
- d_rdata  out  16  read data (m_rdata[15:0]), valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request, high for the whole BUSY state.
- m_we  out  1  memory write enable.
- m_addr  out  16  memory address.
- m_wdata  out  17  memory write data, {1'b0, d_wdata}.
- m_rdata  in  17  memory read data, valid with m_ack.
- m_ack  in  1  memory completion, sampled only in BUSY.
- stall  out  1  high whenever any request is pending and not completing this cycle.
- err  out  1  one-cycle pulse, coincident with ready, on timeout or illegal request.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request is present, grant one, latch its address, write data, direction and owner, clear the timeout counter, and go to BUSY. Otherwise stay in IDLE.
- Priority: data requests beat fetch, because data belongs to the older instruction.
- Starvation override: fetch wins when if_req is high and the starvation counter equals STARVE_LIMIT.
- Starvation counter:
  - increments on each data grant made while if_req=1;
  - clears on a fetch grant, or in any cycle in which if_req=0;
  - saturates at STARVE_LIMIT.
- d_read and d_write both high: treated as a write, and err pulses with d_ready.
- BUSY: m_req=1, and m_addr/m_we/m_wdata are driven from the latched registers; they are stable for the whole state.
  - On m_ack: capture m_rdata and go to DONE.
  - If the timeout counter reaches TIMEOUT first: capture 0, set the error flag, and go to DONE.
- DONE: assert the owner's ready (if_ready or d_ready) with the captured data, pulse err if flagged, then go to IDLE. No grant is made in DONE, so a requester sees ready and drops its request before the next arbitration.
- m_ack in IDLE or DONE is ignored.
- Requests that drop while in BUSY do not abort the access; the access completes and ready still pulses.
- Writes: the ready pulse is returned, and d_rdata equals the captured m_rdata[15:0] (don't-care for the CPU).

## Timing
- Reset values:
  - state=IDLE;
  - m_req=0, m_we=0, m_addr=0, m_wdata=0;
  - if_ready=0, d_ready=0, err=0;
  - if_rdata=0, d_rdata=0;
  - both counters=0.
- Reset asserted mid-BUSY drops m_req asynchronously. The in-flight access is lost and no ready is issued.
- Latency (request seen at edge N, m_ack high in the first BUSY cycle):
  - m_req high in cycle N+1;
  - ready high in cycle N+2;
  - next grant decided at edge N+3.
  - Minimum is 3 cycles per access. Each memory wait cycle adds 1.
- Outputs m_*, ready, rdata and err are registered or decoded from state only; there is no combinational path from requests to m_*.
- stall = (if_req | d_read | d_write) & ~(if_ready | d_ready).
- Timeout: with TIMEOUT=T and no ack, BUSY lasts exactly T cycles, and DONE with err=1 follows.

## Test plan
- Single fetch, zero-wait memory: if_req=1, if_addr=0x0010, memory returns 0x1ABCD with ack on the first BUSY cycle. Required: m_req high in cycle 1, if_ready=1 with if_rdata=0x1ABCD in cycle 2, stall low from cycle 2.
- Simultaneous if_req and d_read (d_addr=0x0200, mem=0x01234). Required: data granted first and d_rdata=0x1234; then fetch granted at the following IDLE, with if_ready 3 cycles after d_ready.
- Starvation: STARVE_LIMIT=2, if_req held high, d_read reasserted continuously. Required: grant order data, data, fetch, data, data, fetch.
- Timeout: TIMEOUT=5, d_write with m_ack held at 0. Required: m_req high for exactly 5 cycles, m_we=1 throughout; then d_ready=1 and err=1 for one cycle, d_rdata=0, and the FSM is back in IDLE.
- Reset mid-access: reset driven low during BUSY, between clock edges. Required: m_req=0 immediately and no ready pulse. After release with if_req=1, normal fetch resumes with 3-cycle latency.
- Illegal request: d_read=d_write=1, d_wdata=0xBEEF. Required: m_we=1, m_wdata=0x0BEEF, and err pulses with d_ready.
